// File: rtl/mac_result_pkg.sv
// Shared types, default geometry and saturation limits for the MAC result bank.
package mac_result_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

  localparam int unsigned RES_DATA_W    = 16;
  localparam int unsigned RES_DEPTH     = 8;
  localparam int unsigned RES_ADDR_W    = 4;
  localparam int unsigned RES_BASE_ADDR = 2;

  // Most positive two's-complement value of width w, in the low w bits.
  function automatic logic [63:0] res_sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width w, in the low w bits.
  function automatic logic [63:0] res_sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/mac_result_clear_seq.sv
// Bank-clear sequencer: walks the entry index 0..DEPTH-1, one zeroing write per cycle.
module mac_result_clear_seq
  import mac_result_pkg::*;
#(
  parameter int unsigned DEPTH = RES_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_clr_we,
  output logic [IDX_W-1:0] o_clr_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  clr_state_e       r_state;
  clr_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = 1'b0;
    o_clr_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        o_busy   = 1'b1;
        o_clr_we = 1'b1;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_clr_idx = r_cnt;

endmodule

// File: rtl/mac_result_bank.sv
// Result register bank: write / accumulate / registered read, plus a sequenced bank clear.
// Define MAC_RESULT_SAT_EN to saturate accumulates on signed overflow instead of wrapping.
module mac_result_bank
  import mac_result_pkg::*;
#(
  parameter int unsigned DATA_W    = RES_DATA_W,
  parameter int unsigned DEPTH     = RES_DEPTH,
  parameter int unsigned ADDR_W    = RES_ADDR_W,
  parameter int unsigned BASE_ADDR = RES_BASE_ADDR
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mac_en,
  input  logic              i_wr_en,
  input  logic              i_acc_en,
  input  logic              i_rd_en,
  input  logic              i_clr_start,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_valid,
  output logic              o_addr_err,
  output logic              o_busy,
  output logic              o_ovf
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_addr_err;
  logic              r_ovf;

  logic [31:0]       w_addr_ext;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_req_ok;
  logic              w_wr;
  logic              w_rd;
  logic              w_err;
  logic              w_busy;
  logic              w_clr_go;
  logic              w_clr_we;
  logic [IDX_W-1:0]  w_clr_idx;
  logic [DATA_W-1:0] w_cur;
  logic [DATA_W-1:0] w_sum;
  logic              w_acc_ovf;
  logic [DATA_W-1:0] w_acc_res;
  logic [DATA_W-1:0] w_wdata;

  // Address decode against the bank window.
  assign w_addr_ext = 32'(i_address);
  assign w_in_range = (w_addr_ext >= BASE_ADDR) && (w_addr_ext < BASE_ADDR + DEPTH);
  assign w_idx      = IDX_W'(w_addr_ext - BASE_ADDR);

  // Requests are only honoured while enabled and not clearing.
  assign w_req_ok = i_mac_en && !w_busy;
  assign w_wr     = w_req_ok && i_wr_en && w_in_range;
  assign w_rd     = w_req_ok && i_rd_en && w_in_range;
  assign w_err    = w_req_ok && (i_wr_en || i_rd_en) && !w_in_range;
  assign w_clr_go = i_mac_en && i_clr_start && !w_busy;

  // Signed overflow: operands agree in sign and the sum does not.
  assign w_cur     = w_in_range ? r_mem[w_idx] : '0;
  assign w_sum     = w_cur + i_din;
  assign w_acc_ovf = (w_cur[DATA_W-1] == i_din[DATA_W-1]) &&
                     (w_sum[DATA_W-1] != w_cur[DATA_W-1]);

`ifdef MAC_RESULT_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(res_sat_max(DATA_W));
  localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(res_sat_min(DATA_W));

  assign w_acc_res = w_acc_ovf ? (i_din[DATA_W-1] ? SAT_MIN : SAT_MAX) : w_sum;
`else
  assign w_acc_res = w_sum;
`endif

  assign w_wdata = i_acc_en ? w_acc_res : i_din;

  mac_result_clear_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clear_seq (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_clr_go),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_idx (w_clr_idx)
  );

  // Storage. Clear and bus writes never coincide: bus writes are blocked while busy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_clr_we) begin
        r_mem[w_clr_idx] <= '0;
      end
      if (w_wr) begin
        r_mem[w_idx] <= w_wdata;
      end
    end
  end

  // Read port samples the array before this edge's write lands (read-before-write).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_dout_valid <= w_rd;
      r_addr_err   <= w_err;
      if (w_rd) begin
        r_dout <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (w_clr_go) begin
      r_ovf <= 1'b0;
    end else if (w_wr && i_acc_en && w_acc_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_addr_err   = r_addr_err;
  assign o_busy       = w_busy;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_mac_result_bank.sv
// Scoreboard bench for mac_result_bank: stimulus queues expected responses, a monitor checks them.
module tb_mac_result_bank;

  logic        clk;
  logic        rst;
  logic        mac_en;
  logic        wr_en;
  logic        acc_en;
  logic        rd_en;
  logic        clr_start;
  logic [3:0]  address;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dout_valid;
  logic        addr_err;
  logic        busy;
  logic        ovf;

  typedef struct packed {
    logic        is_err;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef MAC_RESULT_SAT_EN
  localparam logic [15:0] ACC_EXP = 16'h7FFF;
`else
  localparam logic [15:0] ACC_EXP = 16'h8010;
`endif

  mac_result_bank #(
    .DATA_W    (16),
    .DEPTH     (8),
    .ADDR_W    (4),
    .BASE_ADDR (2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_mac_en     (mac_en),
    .i_wr_en      (wr_en),
    .i_acc_en     (acc_en),
    .i_rd_en      (rd_en),
    .i_clr_start  (clr_start),
    .i_address    (address),
    .i_din        (din),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .o_addr_err   (addr_err),
    .o_busy       (busy),
    .o_ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every response strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (dout_valid || addr_err) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: valid=%b err=%b dout=%h, required no output",
                 dout_valid, addr_err, dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_kind", {30'd0, addr_err, dout_valid}, e.is_err ? 32'd2 : 32'd1);
        if (!e.is_err) check("dout", {16'd0, dout}, {16'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic acc);
    address = a; din = d; acc_en = acc; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; acc_en = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] e);
    exp_t x;
    x.is_err = 1'b0; x.data = e;
    exp_q.push_back(x);
    address = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_bad(input logic [3:0] a, input logic is_wr);
    exp_t x;
    x.is_err = 1'b1; x.data = '0;
    exp_q.push_back(x);
    address = a; din = 16'hDEAD;
    if (is_wr) wr_en = 1'b1;
    else rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic fill(input logic [15:0] d);
    for (int a = 2; a <= 9; a++) do_write(4'(a), d, 1'b0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; mac_en = 1'b1; wr_en = 1'b0; acc_en = 1'b0; rd_en = 1'b0;
    clr_start = 1'b0; address = '0; din = '0;

    // 1. Reset state
    tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_dout", {16'd0, dout}, 32'd0);
    for (int a = 2; a <= 9; a++) do_read(4'(a), 16'h0000);

    // 2. Write, read, read-before-write
    do_write(4'd5, 16'h1234, 1'b0);
    do_read(4'd5, 16'h1234);
    exp_q.push_back('{is_err: 1'b0, data: 16'h1234});
    address = 4'd5; din = 16'hBEEF; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    do_read(4'd5, 16'hBEEF);

    // 3. Accumulate overflow
    do_write(4'd3, 16'h7FF0, 1'b0);
    check("ovf_before_acc", {31'd0, ovf}, 32'd0);
    do_write(4'd3, 16'h0020, 1'b1);
    check("ovf_after_acc", {31'd0, ovf}, 32'd1);
    do_read(4'd3, ACC_EXP);

    // 4. Out-of-range accesses at both edges of the window
    do_read(4'd5, 16'hBEEF);
    do_bad(4'd1, 1'b0);
    check("dout_hold_err", {16'd0, dout}, 32'h0000BEEF);
    do_bad(4'd10, 1'b0);
    do_bad(4'd1, 1'b1);
    do_bad(4'd10, 1'b1);
    do_read(4'd2, 16'h0000);
    do_read(4'd9, 16'h0000);
    do_read(4'd3, ACC_EXP);

    // 5. Full clear sequence with a dropped mid-clear write and read
    fill(16'hA5A5);
    check("ovf_pre_clear", {31'd0, ovf}, 32'd1);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("ovf_clear_entry", {31'd0, ovf}, 32'd0);
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      if (cnt == 3) begin
        address = 4'd2; din = 16'h1111; wr_en = 1'b1;
      end else if (cnt == 5) begin
        address = 4'd2; rd_en = 1'b1; clr_start = 1'b1;
      end
      tick();
      wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
    end
    check("busy_cycles", cnt, 32'd8);
    check("busy_done", {31'd0, busy}, 32'd0);
    for (int a = 2; a <= 9; a++) do_read(4'(a), 16'h0000);

    // 6. Reset during clear, then clr_start ignored while disabled
    fill(16'h5A5A);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cnt = 0;
    while (busy && cnt < 2) begin
      cnt++;
      tick();
    end
    check("busy_clear_cycle3", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("busy_after_rst", {31'd0, busy}, 32'd0);
    for (int a = 2; a <= 9; a++) do_read(4'(a), 16'h0000);
    do_write(4'd7, 16'h0042, 1'b0);
    mac_en = 1'b0;
    clr_start = 1'b1; address = 4'd7; rd_en = 1'b1;
    tick();
    clr_start = 1'b0; rd_en = 1'b0;
    tick();
    check("busy_mac_en_off", {31'd0, busy}, 32'd0);
    mac_en = 1'b1;
    do_read(4'd7, 16'h0042);

    tick();
    tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
